// File: rtl/wb_stream_dma.sv
// ============================================================================
// Module      : wb_stream_dma
// Description : Wishbone master DMA. It reads LEN source words and streams them out,
//               then collects LEN result words and writes them back to the destination.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stream_dma #(
  parameter int LEN_W     = 16,
  parameter int RX_DEPTH  = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             tlast_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             out_tvalid,
  output logic [31:0]      out_tdata,
  output logic             out_tlast,
  input  logic             out_tready,
  input  logic             in_tvalid,
  input  logic [31:0]      in_tdata,
  input  logic             in_tlast,
  output logic             in_tready
);

  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, adr_q, adr_d;
  logic [LEN_W-1:0] len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d, sent_q, sent_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             cyc_q, cyc_d, we_q, we_d;

  logic [31:0]      rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
  logic [RX_AW:0]   rx_occ_q;
  logic [31:0]       out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wp_q, out_rp_q;
  logic [OUT_AW:0]   out_occ_q;

  logic w_ack, w_rx_push, w_rx_pop, w_out_push, w_out_pop, w_accept, w_last_beat;

  assign w_ack       = cyc_q & wbm_ack_i;
  assign w_accept    = (state_q == S_IDLE) & start;
  assign in_tready   = busy_q & (rx_occ_q != (RX_AW+1)'(RX_DEPTH)) & (rx_cnt_q < len_q);
  assign w_rx_push   = in_tvalid & in_tready;
  assign w_rx_pop    = (state_q == S_WR) & w_ack;
  assign out_tvalid  = (out_occ_q != '0);
  assign w_out_push  = (state_q == S_RD) & w_ack;
  assign w_out_pop   = out_tvalid & out_tready;
  assign w_last_beat = (rx_cnt_q == len_q - LEN_W'(1));

  assign busy      = busy_q;
  assign done      = done_q;
  assign tlast_err = err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = (cyc_q & we_q) ? rx_mem[rx_rp_q] : 32'h0;
  assign out_tdata = out_tvalid ? out_mem[out_rp_q] : 32'h0;
  assign out_tlast = out_tvalid & (sent_q == len_q - LEN_W'(1));

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    adr_d    = adr_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rx_cnt_d = rx_cnt_q;
    sent_d   = sent_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ARB;
          src_d    = src_addr;
          dst_d    = dst_addr;
          len_d    = len;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          rx_cnt_d = '0;
          sent_d   = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_ARB: begin
        // Pending results go first so the accelerator's output never backs up.
        if (rx_occ_q != '0) begin
          state_d = S_WR;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = dst_q + (32'(wr_cnt_q) << 2);
        end else if ((rd_cnt_q < len_q) && (out_occ_q != (OUT_AW+1)'(OUT_DEPTH))) begin
          state_d = S_RD;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = src_q + (32'(rd_cnt_q) << 2);
        end else if ((wr_cnt_q == len_q) && (out_occ_q == '0) && (sent_q == len_q)) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_RD: begin
        if (w_ack) begin
          rd_cnt_d = rd_cnt_q + LEN_W'(1);
          cyc_d    = 1'b0;
          state_d  = S_ARB;
        end
      end
      S_WR: begin
        if (w_ack) begin
          wr_cnt_d = wr_cnt_q + LEN_W'(1);
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          state_d  = S_ARB;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A misplaced tlast is flagged but the word is still taken.
    if (w_rx_push) begin
      rx_cnt_d = rx_cnt_q + LEN_W'(1);
      if (in_tlast != w_last_beat) err_d = 1'b1;
    end
    if (w_out_pop) sent_d = sent_q + LEN_W'(1);
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      adr_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rx_cnt_q <= '0;
      sent_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      adr_q    <= adr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      sent_q   <= sent_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_occ_q  <= '0;
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_occ_q <= '0;
    end else if (w_accept) begin
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_occ_q  <= '0;
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_occ_q <= '0;
    end else begin
      if (w_rx_push) rx_wp_q <= rx_wp_q + RX_AW'(1);
      if (w_rx_pop)  rx_rp_q <= rx_rp_q + RX_AW'(1);
      if (w_rx_push && !w_rx_pop)      rx_occ_q <= rx_occ_q + (RX_AW+1)'(1);
      else if (!w_rx_push && w_rx_pop) rx_occ_q <= rx_occ_q - (RX_AW+1)'(1);
      if (w_out_push) out_wp_q <= out_wp_q + OUT_AW'(1);
      if (w_out_pop)  out_rp_q <= out_rp_q + OUT_AW'(1);
      if (w_out_push && !w_out_pop)      out_occ_q <= out_occ_q + (OUT_AW+1)'(1);
      else if (!w_out_push && w_out_pop) out_occ_q <= out_occ_q - (OUT_AW+1)'(1);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (w_rx_push)  rx_mem[rx_wp_q]   <= in_tdata;
    if (w_out_push) out_mem[out_wp_q] <= wbm_dat_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stream_dma.sv
// ============================================================================
// Module      : tb_wb_stream_dma
// Description : Directed bench for wb_stream_dma with Wishbone slave and stream models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stream_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done, tlast_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack;
  logic        out_tvalid, out_tlast, out_tready;
  logic [31:0] out_tdata;
  logic        in_tvalid, in_tlast, in_tready;
  logic [31:0] in_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  int          ack_wait = 1;
  int          wcnt = 0;
  logic        tready_en = 1'b1;
  logic        in_en = 1'b0;
  int          in_idx = 0;
  int          done_cnt = 0;
  logic        cyc_seen = 1'b0;
  logic        tv_seen = 1'b0;
  logic [31:0] in_dat[$];
  logic        in_last[$];
  logic [31:0] rd_adr[$], wr_adr[$], wr_dat[$], out_dat[$];
  logic        out_last[$], txn_we[$];

  wb_stream_dma dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .start(start),
    .src_addr(src), .dst_addr(dst), .len(len),
    .busy(busy), .done(done), .tlast_err(tlast_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .out_tready(out_tready),
    .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .in_tready(in_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    rd_adr.delete(); wr_adr.delete(); wr_dat.delete();
    out_dat.delete(); out_last.delete(); txn_we.delete();
    in_dat.delete(); in_last.delete();
    in_idx = 0; done_cnt = 0; cyc_seen = 1'b0; tv_seen = 1'b0;
  endtask

  task automatic load_in(input logic [31:0] base, input int n, input logic [7:0] lastmask);
    for (int i = 0; i < n; i++) begin
      in_dat.push_back(base + 32'(i));
      in_last.push_back(lastmask[i]);
    end
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (done !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  // Slave, stream sink and stream source all act at the negedge so the DUT samples stable values.
  initial begin
    ack = 1'b0; dat_i = '0; out_tready = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (cyc) cyc_seen = 1'b1;
      if (out_tvalid) tv_seen = 1'b1;
      if (ack) begin
        ack = 1'b0; wcnt = 0;
      end else if (cyc) begin
        wcnt++;
        if (wcnt > ack_wait) begin
          ack = 1'b1;
          txn_we.push_back(we);
          if (we) begin
            wr_adr.push_back(adr); wr_dat.push_back(dat_o);
          end else begin
            rd_adr.push_back(adr); dat_i = adr + 32'h0100_0000;
          end
        end
      end else begin
        wcnt = 0;
      end
      if (out_tvalid && tready_en) begin
        out_dat.push_back(out_tdata); out_last.push_back(out_tlast);
      end
      out_tready = tready_en;
      if (in_en && in_idx < in_dat.size()) begin
        in_tvalid = 1'b1; in_tdata = in_dat[in_idx]; in_tlast = in_last[in_idx];
        if (in_tready) in_idx++;
      end else begin
        in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] m;
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_tvalid", {31'd0, out_tvalid}, 32'd0);
    check("rst_tready", {31'd0, in_tready}, 32'd0);
    check("rst_err", {31'd0, tlast_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic len=4 transfer, one wait state
    clear_logs(); ack_wait = 1; tready_en = 1'b1;
    load_in(32'hC100_0000, 4, 8'b1000); in_en = 1'b1;
    do_start(32'h3800_0000, 32'h3800_1000, 16'd4);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cyc_early", {31'd0, cyc}, 32'd0);
    @(negedge clk);
    check("t1_cyc", {31'd0, cyc}, 32'd1);
    check("t1_stb", {31'd0, stb}, 32'd1);
    check("t1_sel", {28'd0, sel}, 32'hF);
    check("t1_we", {31'd0, we}, 32'd0);
    check("t1_adr0", adr, 32'h3800_0000);
    wait_done("t1_done", 300);
    repeat (2) @(negedge clk);
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_nrd", rd_adr.size(), 32'd4);
    check("t1_rd3", rd_adr[3], 32'h3800_000C);
    check("t1_nout", out_dat.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("t1_out", out_dat[i], 32'h3900_0000 + 32'(4*i));
    m = '0;
    for (int i = 0; i < out_last.size() && i < 8; i++) m[i] = out_last[i];
    check("t1_last", {24'd0, m}, 32'h08);
    check("t1_nwr", wr_adr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_wadr", wr_adr[i], 32'h3800_1000 + 32'(4*i));
      check("t1_wdat", wr_dat[i], 32'hC100_0000 + 32'(i));
    end
    check("t1_err", {31'd0, tlast_err}, 32'd0);

    // 2: len=0
    in_en = 1'b0; clear_logs();
    do_start(32'h3800_0000, 32'h3800_1000, 16'd0);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy_fin", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t2_done_pulse", {31'd0, done}, 32'd0);
    check("t2_cyc_seen", {31'd0, cyc_seen}, 32'd0);
    check("t2_tv_seen", {31'd0, tv_seen}, 32'd0);

    // 3: downstream stall holds reads to the out FIFO depth
    clear_logs(); tready_en = 1'b0;
    do_start(32'h3800_0200, 32'h3800_1200, 16'd8);
    repeat (20) @(negedge clk);
    check("t3_nrd_stall", rd_adr.size(), 32'd2);
    check("t3_cyc_idle", {31'd0, cyc}, 32'd0);
    check("t3_tvalid", {31'd0, out_tvalid}, 32'd1);
    load_in(32'hC300_0000, 8, 8'b1000_0000); in_en = 1'b1; tready_en = 1'b1;
    wait_done("t3_done", 500);
    check("t3_nout", out_dat.size(), 32'd8);
    for (int i = 0; i < 8; i++) check("t3_out", out_dat[i], 32'h3900_0200 + 32'(4*i));
    m = '0;
    for (int i = 0; i < out_last.size() && i < 8; i++) m[i] = out_last[i];
    check("t3_last", {24'd0, m}, 32'h80);
    check("t3_wdat7", wr_dat[7], 32'hC300_0007);
    repeat (2) @(negedge clk);

    // 4: result burst during a slow read gives writes priority
    clear_logs(); in_en = 1'b0; ack_wait = 10;
    load_in(32'hC400_0000, 8, 8'b1000_0000); in_en = 1'b1;
    do_start(32'h3800_0100, 32'h3800_1100, 16'd8);
    repeat (7) @(negedge clk);
    check("t4_rd_pending", {30'd0, cyc, we}, 32'd2);
    check("t4_tready_full", {31'd0, in_tready}, 32'd0);
    wait_done("t4_done", 1500);
    check("t4_ntxn", txn_we.size(), 32'd16);
    check("t4_second_wr", {31'd0, txn_we[1]}, 32'd1);
    for (int i = 0; i < 8; i++) check("t4_wdat", wr_dat[i], 32'hC400_0000 + 32'(i));
    check("t4_wadr7", wr_adr[7], 32'h3800_111C);
    check("t4_out7", out_dat[7], 32'h3900_011C);
    repeat (2) @(negedge clk);

    // 5: tlast on the wrong beat
    clear_logs(); in_en = 1'b0; ack_wait = 1;
    load_in(32'hC500_0000, 4, 8'b0000_0010); in_en = 1'b1;
    do_start(32'h3800_0300, 32'h3800_1300, 16'd4);
    wait_done("t5_done", 300);
    check("t5_err", {31'd0, tlast_err}, 32'd1);
    check("t5_nwr", wr_adr.size(), 32'd4);
    repeat (2) @(negedge clk);
    check("t5_err_sticky", {31'd0, tlast_err}, 32'd1);
    in_en = 1'b0; clear_logs();
    do_start(32'h3800_0000, 32'h3800_1000, 16'd0);
    check("t5_err_clr", {31'd0, tlast_err}, 32'd0);
    wait_done("t5_done2", 10);
    repeat (2) @(negedge clk);

    // 6: asynchronous reset mid-read, then restart
    clear_logs(); ack_wait = 50;
    do_start(32'h3800_0400, 32'h3800_1400, 16'd4);
    repeat (3) @(negedge clk);
    check("t6_cyc_before", {31'd0, cyc}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_cyc_async", {31'd0, cyc}, 32'd0);
    check("t6_stb_async", {31'd0, stb}, 32'd0);
    check("t6_busy_async", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ack_wait = 1;
    @(negedge clk);
    clear_logs();
    load_in(32'hC600_0000, 2, 8'b0000_0010); in_en = 1'b1;
    do_start(32'h3800_0800, 32'h3800_1800, 16'd2);
    wait_done("t6_done", 300);
    check("t6_nrd", rd_adr.size(), 32'd2);
    check("t6_rd0", rd_adr[0], 32'h3800_0800);
    check("t6_rd1", rd_adr[1], 32'h3800_0804);
    check("t6_wadr0", wr_adr[0], 32'h3800_1800);
    check("t6_wdat1", wr_dat[1], 32'hC600_0001);
    check("t6_out1", out_dat[1], 32'h3900_0804);
    check("t6_err", {31'd0, tlast_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
